// File: rtl/mem_pkg.sv
// mem_pkg: shared size encodings, FSM state type and default address width
// for the data-memory access controller and its lane-alignment helper.
package mem_pkg;
    localparam int MEM_ADDR_W = 12;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_RESP} state_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian lane extraction/extension for loads and
// byte/half merge for stores.
//   old_word  in  32  word currently in memory
//   lane      in  2   byte offset within the word
//   size      in  2   SZ_BYTE / SZ_HALF / SZ_WORD
//   sgn       in  1   sign-extend loads when 1
//   wdata     in  32  right-aligned store data
//   ld_data   out 32  extended load value
//   st_word   out 32  old_word with the addressed lanes replaced by wdata
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);
    logic [4:0]  sh;
    logic [31:0] shifted;
    logic [31:0] mask;
    always_comb begin
        sh       = {lane, 3'b000};
        shifted  = old_word >> sh;
        mask     = (size == SZ_BYTE) ? (32'h0000_00ff << sh) :
                   (size == SZ_HALF) ? (32'h0000_ffff << sh) : 32'hffff_ffff;
        ld_data  = (size == SZ_BYTE) ? {{24{sgn & shifted[7]}}, shifted[7:0]} :
                   (size == SZ_HALF) ? {{16{sgn & shifted[15]}}, shifted[15:0]} : old_word;
        st_word  = (old_word & ~mask) | ((wdata << sh) & mask);
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: valid/ready load/store front end for a word-wide dual-port
// memory; read-modify-write for sub-word stores, extended loads, one response
// per request.
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         request handshake
//   req_we/size/signed/addr/wdata  request fields (byte address)
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata/rsp_err           response payload
//   mem_a/mem_d/mem_we          synchronous write port
//   mem_dpra/mem_dpo            asynchronous read port
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_a,
    output logic [31:0]       mem_d,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_dpra,
    input  logic [31:0]       mem_dpo
);
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [1:0]          lane_q, lane_d;
    logic [1:0]          size_q, size_d;
    logic                sgn_q, sgn_d;
    logic                we_q, we_d;
    logic [31:0]         wd_q, wd_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                bad;
    logic [31:0]         ld_data;
    logic [31:0]         st_word;

    mem_lane_align u_align (
        .old_word (mem_dpo),
        .lane     (lane_q),
        .size     (size_q),
        .sgn      (sgn_q),
        .wdata    (wd_q),
        .ld_data  (ld_data),
        .st_word  (st_word)
    );

    always_comb begin
        bad = (req_size == 2'b11) |
              ((req_size == SZ_HALF) & req_addr[0]) |
              ((req_size == SZ_WORD) & (|req_addr[1:0])) |
              (|req_addr[31:ADDR_W+2]);
        state_d = state_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        we_d    = we_q;
        wd_d    = wd_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: if (req_valid) begin
                idx_d   = req_addr[ADDR_W+1:2];
                lane_d  = req_addr[1:0];
                size_d  = req_size;
                sgn_d   = req_signed;
                we_d    = req_we;
                wd_d    = req_wdata;
                rdata_d = '0;
                err_d   = bad;
                state_d = bad ? ST_RESP : (req_we && req_size == SZ_WORD) ? ST_WRITE : ST_READ;
            end
            // wd_q is reused: it holds the raw store data until the merged word replaces it
            ST_READ: begin
                wd_d    = we_q ? st_word : wd_q;
                rdata_d = we_q ? rdata_q : ld_data;
                state_d = we_q ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = rsp_ready ? ST_IDLE : ST_RESP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            lane_q  <= '0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            we_q    <= 1'b0;
            wd_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            we_q    <= we_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_a     = idx_q;
    assign mem_dpra  = idx_q;
    assign mem_d     = wd_q;
    // gated by rst so the aborting reset edge cannot commit a write
    assign mem_we    = (state_q == ST_WRITE) & ~rst;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed bench with a byte-level reference memory model.
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [11:0] mem_a, mem_dpra;
    logic [31:0] mem_d, mem_dpo;
    logic        mem_we;

    logic [31:0] dmem    [4096];
    logic [31:0] ref_mem [4096];
    logic [32:0] rsp_q [$];
    logic [43:0] wr_q  [$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we),
        .mem_dpra(mem_dpra), .mem_dpo(mem_dpo)
    );

    always @(posedge clk) if (mem_we) dmem[mem_a] <= mem_d;
    assign mem_dpo = dmem[mem_dpra];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) if (!rst) begin
        if (mem_we) begin
            if (wr_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL wr_unexpected: got write a=%h d=%h expected none", mem_a, mem_d);
            end else begin
                logic [43:0] e;
                e = wr_q.pop_front();
                chk("wr_addr", 32'(mem_a), 32'(e[43:32]));
                chk("wr_data", mem_d, e[31:0]);
            end
        end
        if (rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rsp_unexpected: got response %h expected none", rsp_rdata);
            end else begin
                logic [32:0] r;
                r = rsp_q.pop_front();
                chk("rsp_err", 32'(rsp_err), 32'(r[32]));
                chk("rsp_rdata", rsp_rdata, r[31:0]);
            end
        end
    end

    task automatic preload(input logic [31:0] addr, input logic [31:0] w);
        dmem[addr[13:2]]    = w;
        ref_mem[addr[13:2]] = w;
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int hold, output logic [31:0] got);
        int n, lat, k, nw, waited;
        logic err;
        logic [31:0] v, r0;
        logic [13:0] a;
        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err = (size == 2'd3) || ((addr % n) != 0) || (addr >= 32'h4000);
        v   = '0;
        got = '0;
        if (!err && !we) begin
            for (int i = 0; i < n; i++) begin
                a = addr[13:0] + 14'(i);
                v = v | (32'(ref_mem[a[13:2]][{a[1:0], 3'b000} +: 8]) << (8 * i));
            end
            if (sgn && n < 4 && v[8*n-1]) v = v | (32'hffff_ffff << (8 * n));
        end
        if (!err && we) begin
            for (int i = 0; i < n; i++) begin
                a = addr[13:0] + 14'(i);
                ref_mem[a[13:2]][{a[1:0], 3'b000} +: 8] = wdata[8*i +: 8];
            end
            wr_q.push_back({addr[13:2], ref_mem[addr[13:2]]});
        end
        rsp_q.push_back({err, v});
        lat = err ? 1 : (we && size != 2'd2) ? 3 : 2;
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!req_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL req_ready_timeout: got req_ready=0 expected 1 within 20 cycles");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        k = 0; nw = 0;
        do begin
            k++;
            @(negedge clk);
            if (mem_we) nw++;
        end while (!rsp_valid && k < 20);
        if (!rsp_valid) begin
            n_cmp++; n_bad++;
            $display("FAIL rsp_timeout: got no rsp_valid expected it at cycle %0d", lat);
            return;
        end
        chk("latency", 32'(k), 32'(lat));
        chk("write_count", 32'(nw), (we && !err) ? 32'd1 : 32'd0);
        r0 = rsp_rdata;
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                @(negedge clk);
                chk("bp_valid", 32'(rsp_valid), 32'd1);
                chk("bp_rdata", rsp_rdata, r0);
                chk("bp_req_ready", 32'(req_ready), 32'd0);
            end
            @(posedge clk); #1;
            rsp_ready = 1'b1;
            @(negedge clk);
        end
        got = rsp_rdata;
        @(posedge clk); #1;
        chk("ready_after_hs", 32'(req_ready), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata,      32'd0);
        chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
        chk({tag, "_mem_a"},     32'(mem_a),     32'd0);
        chk({tag, "_mem_dpra"},  32'(mem_dpra),  32'd0);
        chk({tag, "_mem_d"},     mem_d,          32'd0);
    endtask

    initial begin
        logic [31:0] g;
        for (int i = 0; i < 4096; i++) begin
            dmem[i] = '0;
            ref_mem[i] = '0;
        end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;

        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, g);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, g);
        chk("pin_word_load", g, 32'hDEADBEEF);

        preload(32'h20, 32'h11223344);
        do_req(1'b1, 2'd0, 1'b0, 32'h22, 32'h000000AA, 0, g);
        chk("pin_byte_store_mem", dmem[8], 32'h11AA3344);
        chk("pin_byte_store_rsp", g, 32'h0);

        preload(32'h30, 32'h80FF7F01);
        do_req(1'b0, 2'd0, 1'b1, 32'h32, 32'h0, 0, g);
        chk("pin_sbyte", g, 32'hFFFFFFFF);
        do_req(1'b0, 2'd0, 1'b0, 32'h32, 32'h0, 0, g);
        chk("pin_ubyte", g, 32'h000000FF);
        do_req(1'b0, 2'd1, 1'b1, 32'h30, 32'h0, 0, g);
        chk("pin_shalf_lo", g, 32'h00007F01);
        do_req(1'b0, 2'd1, 1'b1, 32'h32, 32'h0, 0, g);
        chk("pin_shalf_hi", g, 32'hFFFF80FF);

        do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234BEEF, 0, g);
        chk("pin_half_store_mem", dmem[8], 32'hBEEF3344);
        do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 0, g);
        chk("pin_uhalf", g, 32'h0000BEEF);
        do_req(1'b1, 2'd0, 1'b0, 32'h21, 32'hFFFFFF7E, 0, g);
        do_req(1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 0, g);
        chk("pin_sbyte_pos", g, 32'h0000007E);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, g);
        chk("pin_merged_word", g, 32'hBEEF7E44);

        do_req(1'b0, 2'd1, 1'b1, 32'h31, 32'h0, 0, g);
        chk("pin_err_half", g, 32'h0);
        do_req(1'b1, 2'd2, 1'b0, 32'h06, 32'hCAFEF00D, 0, g);
        do_req(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 0, g);
        do_req(1'b0, 2'd2, 1'b0, 32'h00010000, 32'h0, 0, g);
        chk("pin_err_range", g, 32'h0);
        chk("err_no_write", dmem[1], 32'h0);

        rsp_ready = 1'b0;
        do_req(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 5, g);
        chk("pin_bp_load", g, 32'h80FF7F01);

        preload(32'h40, 32'h55667788);
        req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h41; req_wdata = 32'h99; req_valid = 1'b1;
        chk("rst_pre_idle", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_write", 32'(mem_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_we_gated", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        chk_reset_outputs("abort");
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        chk("abort_mem_unchanged", dmem[16], 32'h55667788);

        chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Requester-side controller that drives the word-wide dual-port data memory (12-bit word address, 32-bit data, synchronous write port, asynchronous read port).
- Accepts byte, halfword and word load/store requests from the MIPS datapath over a valid/ready handshake.
- Performs read-modify-write for sub-word stores and sign/zero-extends loads.
- Returns one response per request.

Parameters:
- ADDR_W, 12, word-address width of the memory; the byte address space is 2^(ADDR_W+2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  load sign-extend when 1, zero-extend when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  request rejected.
- mem_a  out  ADDR_W  write word address.
- mem_d  out  32  write data.
- mem_we  out  1  write enable.
- mem_dpra  out  ADDR_W  read word address.
- mem_dpo  in  32  read data, combinational from mem_dpra.

Behaviour:
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_we=0, mem_a=mem_dpra=0, mem_d=0.
- Reset mid-operation aborts the request with no response. mem_we = (state==WRITE) & ~rst, so no write occurs on the reset edge.
- Byte lanes are little-endian. lane = addr[1:0]; word index = addr[ADDR_W+1:2].
- Error conditions, checked at acceptance:
  - req_size==11.
  - half with addr[0]=1.
  - word with addr[1:0]!=0.
  - addr[31:ADDR_W+2] nonzero.
- On an error: go to RESP with rsp_err=1 and rsp_rdata=0; no memory access.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1. Acceptance happens when req_valid & req_ready.
  - On acceptance, latch the word index, lane, size, signed, we and wdata.
  - Next state: error → RESP; load → READ; word store → WRITE; byte/half store → READ.
- READ:
  - mem_dpra = latched index.
  - Load: capture mem_dpo, extract the selected lane, extend to 32 bits, go to RESP.
  - Sub-word store: register the merged word (old word with the selected byte/half replaced by req_wdata[7:0] or [15:0]), go to WRITE.
- WRITE:
  - mem_a = latched index, mem_d = merged or full word, mem_we=1 for exactly one cycle.
  - Then go to RESP.
- RESP:
  - rsp_valid=1, with outputs held stable until rsp_ready.
  - On rsp_valid & rsp_ready go to IDLE.
  - req_ready=0 in every state except IDLE.
- Latency with rsp_ready held high (accept edge = cycle 0; rsp_valid asserted in the cycle shown):
  - Error: cycle 1.
  - Load: cycle 2.
  - Word store: write edge ends cycle 1, response cycle 2.
  - Sub-word store: read cycle 1, write cycle 2, response cycle 3.
- Back-to-back: the next request is accepted on the cycle after the response handshake, so a store to address X followed by a load of X returns the new data.
- mem_dpra tracks the latched index in all states, because the read port is harmless when idle.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - FSM state enum.
  - ADDR_W default.
- One combinational sub-module, mem_lane_align:
  - Inputs: old word, lane, size, signed, wdata.
  - Outputs: extended load data and merged store word.
  - Reusable by future cache logic.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 → mem_we high exactly one cycle with mem_a=4; load rsp_rdata=0xDEADBEEF, rsp_valid at cycle 2.
- Memory word 0x11223344 @0x20, byte store 0xAA @0x22 → memory word becomes 0x11AA3344; response at cycle 3 with rsp_err=0.
- Word 0x80FF7F01 @0x30: signed byte load @0x32 → 0xFFFFFFFF; unsigned byte load @0x32 → 0x000000FF; signed half load @0x30 → 0x00007F01; signed half load @0x32 → 0xFFFF80FF.
- Half load @0x31, word store @0x06, size 11, and addr 0x00010000 → each gives rsp_err=1 at cycle 1, rsp_rdata=0, mem_we never asserted.
- Response backpressure: hold rsp_ready=0 for 5 cycles on a load → rsp_valid and rsp_rdata stay stable and req_ready=0 throughout; the next request is accepted only after the handshake.
- rst asserted during WRITE of a byte store → mem_we=0 on that edge, memory unchanged, all outputs at reset values next cycle, no response.
